// File: rtl/serial_cpu_pkg.sv
// Shared opcode and FSM encodings for the bit-serial ALU and the control unit.
package serial_cpu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDB = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_CMP = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

    // Ops whose carry chain produces meaningful C and V flags.
    function automatic logic op_is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_CMP);
    endfunction

endpackage

// File: rtl/serial_alu_if.sv
// Control-side bundle of the bit-serial ALU: request, operands, result stream and flags.
interface serial_alu_if #(
    parameter int WIDTH = 8
) ();
    localparam int BW = $clog2(WIDTH);

    // start is a request the ALU accepts only while busy is low; no ready is returned,
    // a start seen while busy is dropped, and op/acc_bits/operand_b matter only with it.
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] acc_bits;
    logic [WIDTH-1:0] operand_b;
    logic             busy;
    logic             acc_write_en;
    logic             alu_result;
    logic [BW-1:0]    bit_index_d;
    logic             done;
    logic             carry_flag;
    logic             zero_flag;
    logic             ovf_flag;

    modport master (
        output start, op, acc_bits, operand_b,
        input  busy, acc_write_en, alu_result, bit_index_d,
        input  done, carry_flag, zero_flag, ovf_flag
    );

    modport slave (
        input  start, op, acc_bits, operand_b,
        output busy, acc_write_en, alu_result, bit_index_d,
        output done, carry_flag, zero_flag, ovf_flag
    );

endinterface

// File: rtl/serial_alu_bit_slice.sv
// Combinational one-bit ALU cell; SUB/CMP invert B here, the caller seeds carry-in with 1.
module serial_bit_slice
    import serial_cpu_pkg::*;
(
    input  logic       a_i,
    input  logic       b_i,
    input  logic       a_prev_i,
    input  logic       cin_i,
    input  logic [2:0] op_i,
    output logic       r_o,
    output logic       cout_o
);

    logic b_eff;

    always_comb begin
        r_o    = 1'b0;
        cout_o = 1'b0;
        b_eff  = b_i;
        case (op_i)
            OP_ADD, OP_SUB, OP_CMP: begin
                b_eff  = (op_i == OP_ADD) ? b_i : ~b_i;
                r_o    = a_i ^ b_eff ^ cin_i;
                cout_o = (a_i & b_eff) | (a_i & cin_i) | (b_eff & cin_i);
            end
            OP_AND: r_o = a_i & b_i;
            OP_OR:  r_o = a_i | b_i;
            OP_XOR: r_o = a_i ^ b_i;
            OP_LDB: r_o = b_i;
            // cout carries A[i] forward as the next bit's shift-in.
            OP_SHL: begin
                r_o    = a_prev_i;
                cout_o = a_i;
            end
            default: r_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/serial_alu.sv
// Bit-serial ALU: latches operands on start, streams result bits LSB first, then
// pulses done with the C/Z/V flags. Each bit is computed one cycle ahead into output flops.
module serial_alu
    import serial_cpu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    serial_alu_if.slave  alu_if,
    output state_e       state_o
);

    localparam int            BW   = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [BW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic             carry_q, carry_d, zacc_q, zacc_d, cin_msb_q, cin_msb_d;
    logic             busy_q, busy_d, we_q, we_d, res_q, res_d, done_q, done_d;
    logic [BW-1:0]    idx_q, idx_d;
    logic             c_q, c_d, z_q, z_d, v_q, v_d;

    logic             idle;
    logic [BW-1:0]    sel;
    logic [WIDTH-1:0] src_a, src_b;
    logic [2:0]       src_op;
    logic             s_a, s_b, s_prev, s_cin, s_r, s_cout;

    // In IDLE the slice works on the raw inputs so bit 0 is ready on the start edge.
    always_comb begin
        idle   = (state_q == S_IDLE);
        sel    = idle ? '0 : cnt_q + BW'(1);
        src_a  = idle ? alu_if.acc_bits  : a_q;
        src_b  = idle ? alu_if.operand_b : b_q;
        src_op = idle ? alu_if.op        : op_q;
        s_a    = src_a[sel];
        s_b    = src_b[sel];
        s_prev = (sel == '0) ? 1'b0 : src_a[sel - BW'(1)];
        s_cin  = idle ? ((src_op == OP_SUB) || (src_op == OP_CMP)) : carry_q;
    end

    serial_bit_slice u_slice (
        .a_i      (s_a),
        .b_i      (s_b),
        .a_prev_i (s_prev),
        .cin_i    (s_cin),
        .op_i     (src_op),
        .r_o      (s_r),
        .cout_o   (s_cout)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        carry_d   = carry_q;
        zacc_d    = zacc_q;
        cin_msb_d = cin_msb_q;
        c_d       = c_q;
        z_d       = z_q;
        v_d       = v_q;
        we_d      = 1'b0;
        res_d     = 1'b0;
        idx_d     = '0;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (alu_if.start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    a_d     = alu_if.acc_bits;
                    b_d     = alu_if.operand_b;
                    op_d    = alu_if.op;
                    carry_d = s_cout;
                    zacc_d  = ~s_r;
                    res_d   = s_r;
                    we_d    = (alu_if.op != OP_CMP);
                end
            end
            S_RUN: begin
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    c_d     = (op_is_arith(op_q) || (op_q == OP_SHL)) ? carry_q : 1'b0;
                    z_d     = zacc_q;
                    v_d     = op_is_arith(op_q) ? (cin_msb_q ^ carry_q) : 1'b0;
                end else begin
                    cnt_d   = sel;
                    idx_d   = sel;
                    res_d   = s_r;
                    we_d    = (op_q != OP_CMP);
                    carry_d = s_cout;
                    zacc_d  = zacc_q & ~s_r;
                    if (sel == LAST) cin_msb_d = s_cin;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            carry_q   <= 1'b0;
            zacc_q    <= 1'b0;
            cin_msb_q <= 1'b0;
            busy_q    <= 1'b0;
            we_q      <= 1'b0;
            res_q     <= 1'b0;
            idx_q     <= '0;
            done_q    <= 1'b0;
            c_q       <= 1'b0;
            z_q       <= 1'b0;
            v_q       <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            carry_q   <= carry_d;
            zacc_q    <= zacc_d;
            cin_msb_q <= cin_msb_d;
            busy_q    <= busy_d;
            we_q      <= we_d;
            res_q     <= res_d;
            idx_q     <= idx_d;
            done_q    <= done_d;
            c_q       <= c_d;
            z_q       <= z_d;
            v_q       <= v_d;
        end
    end

    assign alu_if.busy         = busy_q;
    assign alu_if.acc_write_en = we_q;
    assign alu_if.alu_result   = res_q;
    assign alu_if.bit_index_d  = idx_q;
    assign alu_if.done         = done_q;
    assign alu_if.carry_flag   = c_q;
    assign alu_if.zero_flag    = z_q;
    assign alu_if.ovf_flag     = v_q;
    assign state_o             = state_q;

endmodule

// File: tb/tb_serial_alu.sv
// Bench for serial_alu: directed vector table, mid-op reset sequence and random ops
// checked against an arithmetic reference model and a model accumulator.
module tb_serial_alu;
    import serial_cpu_pkg::*;

    logic   clk = 1'b0;
    logic   rst_n;
    state_e state_dbg;
    logic [7:0] acc_m;
    int total = 0;
    int bad   = 0;

    serial_alu_if #(.WIDTH(8)) bus ();

    serial_alu #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .alu_if  (bus),
        .state_o (state_dbg)
    );

    always #5 clk = ~clk;

    // Model accumulator: captures each strobed bit on the following edge.
    always @(posedge clk) begin
        if (bus.acc_write_en) acc_m[bus.bit_index_d] <= bus.alu_result;
    end

    typedef struct {
        string      name;
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r;
        logic       c;
        logic       z;
        logic       v;
        int         s1;
        int         s2;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Returns {v, z, c, r}.
    function automatic logic [10:0] ref_model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int sa, sb, s;
        logic [7:0] r;
        logic c, v;
        sa = $signed(a);
        sb = $signed(b);
        r = 8'h00; c = 1'b0; v = 1'b0;
        case (op)
            OP_ADD: begin
                r = a + b;
                c = (int'(a) + int'(b)) > 255;
                s = sa + sb;
                v = (s > 127) || (s < -128);
            end
            OP_SUB, OP_CMP: begin
                r = a - b;
                c = (a >= b);
                s = sa - sb;
                v = (s > 127) || (s < -128);
            end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_LDB: r = b;
            OP_SHL: begin
                r = {a[6:0], 1'b0};
                c = a[7];
            end
            default: r = 8'h00;
        endcase
        return {v, (r == 8'h00), c, r};
    endfunction

    task automatic run_op(input string name, input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] exp_r, input logic exp_c,
                          input logic exp_z, input logic exp_v, input int s1, input int s2);
        logic [2:0] exp_q[$];
        logic [7:0] exp_acc;
        int done_cyc;
        int busy_low;
        done_cyc = 0;
        busy_low = 0;
        exp_acc = (op == OP_CMP) ? acc_m : exp_r;
        if (op != OP_CMP) for (int i = 0; i < 8; i++) exp_q.push_back(3'(i));
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.acc_bits = a; bus.operand_b = b;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            bus.start     = (cyc == s1) || (cyc == s2);
            bus.op        = 3'($urandom);
            bus.acc_bits  = 8'($urandom);
            bus.operand_b = 8'($urandom);
            if (!bus.busy) busy_low++;
            if (bus.acc_write_en) begin
                if (exp_q.size() == 0) check({name, " unexpected write"}, 1, 0);
                else check({name, " bit index"}, int'(bus.bit_index_d), int'(exp_q.pop_front()));
            end
            if (bus.done) begin
                done_cyc = cyc;
                check({name, " flags CZV"}, {bus.carry_flag, bus.zero_flag, bus.ovf_flag},
                      {exp_c, exp_z, exp_v});
                check({name, " acc"}, acc_m, exp_acc);
                break;
            end
        end
        check({name, " done cycle"}, done_cyc, 9);
        check({name, " writes missing"}, exp_q.size(), 0);
        check({name, " busy low during op"}, busy_low, 0);
        @(negedge clk);
        bus.start = 1'b0;
        check({name, " idle after done busy,done"}, {bus.busy, bus.done}, 0);
    endtask

    initial begin
        logic [10:0] m;
        logic [2:0]  rop;
        logic [7:0]  ra, rb;
        int          late_done;

        vecs.push_back('{"add_3c_05",   OP_ADD, 8'h3C, 8'h05, 8'h41, 1'b0, 1'b0, 1'b0, 0, 0});
        vecs.push_back('{"add_7f_01",   OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 0, 0});
        vecs.push_back('{"shl_81",      OP_SHL, 8'h81, 8'h00, 8'h02, 1'b1, 1'b0, 1'b0, 0, 0});
        vecs.push_back('{"cmp_03_04",   OP_CMP, 8'h03, 8'h04, 8'hFF, 1'b0, 1'b0, 1'b0, 0, 0});
        vecs.push_back('{"add_restart", OP_ADD, 8'h3C, 8'h05, 8'h41, 1'b0, 1'b0, 1'b0, 3, 9});
        vecs.push_back('{"and_f0_3c",   OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 0, 0});
        vecs.push_back('{"or_0f_f0",    OP_OR,  8'h0F, 8'hF0, 8'hFF, 1'b0, 1'b0, 1'b0, 0, 0});
        vecs.push_back('{"xor_aa_aa",   OP_XOR, 8'hAA, 8'hAA, 8'h00, 1'b0, 1'b1, 1'b0, 0, 0});
        vecs.push_back('{"ldb_5a",      OP_LDB, 8'h11, 8'h5A, 8'h5A, 1'b0, 1'b0, 1'b0, 0, 0});
        vecs.push_back('{"sub_80_01",   OP_SUB, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0, 1'b1, 0, 0});
        vecs.push_back('{"sub_05_05",   OP_SUB, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1, 1'b0, 0, 0});

        rst_n = 1'b0;
        bus.start = 1'b0; bus.op = 3'b000; bus.acc_bits = 8'h00; bus.operand_b = 8'h00;
        repeat (3) @(negedge clk);
        check("reset busy", bus.busy, 0);
        check("reset write_en/result/idx", {bus.acc_write_en, bus.alu_result, bus.bit_index_d}, 0);
        check("reset done", bus.done, 0);
        check("reset flags", {bus.carry_flag, bus.zero_flag, bus.ovf_flag}, 0);
        check("reset state", int'(state_dbg), int'(S_IDLE));
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i])
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r,
                   vecs[i].c, vecs[i].z, vecs[i].v, vecs[i].s1, vecs[i].s2);

        // Reset while bit 3 of an ADD is on the write port; flags are nonzero from the SUB above.
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_ADD; bus.acc_bits = 8'h3C; bus.operand_b = 8'h05;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.acc_write_en && bus.bit_index_d == 3'd3) break;
        end
        check("mid-op bit 3 reached", {bus.acc_write_en, bus.bit_index_d}, {1'b1, 3'd3});
        rst_n = 1'b0;
        @(negedge clk);
        check("rst mid-op write_en", bus.acc_write_en, 0);
        check("rst mid-op busy", bus.busy, 0);
        check("rst mid-op flags", {bus.carry_flag, bus.zero_flag, bus.ovf_flag}, 0);
        check("rst mid-op state", int'(state_dbg), int'(S_IDLE));
        rst_n = 1'b1;
        late_done = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.done || bus.busy) late_done++;
        end
        check("no done after reset", late_done, 0);
        run_op("add_after_reset", OP_ADD, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            m   = ref_model(rop, ra, rb);
            run_op($sformatf("rand%0d op%0d a%02h b%02h", n, rop, ra, rb), rop, ra, rb,
                   m[7:0], m[8], m[9], m[10], 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
